// File: rtl/rvfi_pkg.sv
// Shared RVFI trace types: instruction/register widths and the packed trace record.
package rvfi_pkg;

  localparam int ILEN = 32;
  localparam int XLEN = 32;

  // Field order puts pc in the low 32 bits and trap in the MSB of the flattened record.
  typedef struct packed {
    logic            trap;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc;
  } trace_rec_t;

  localparam int TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/sync_fifo.sv
// Circular synchronous FIFO with a separate occupancy counter and a registered-storage
// head that is read combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointers wrap naturally; push and pop together while full leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/rvfi_trace_buffer.sv
// Captures RVFI retirements into a trace FIFO drained over valid/ready, with a saturating
// drop counter, a sticky retirement-order gap flag and freeze-on-trap.
module rvfi_trace_buffer
  import rvfi_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rvfi_valid,
  input  logic [63:0]            rvfi_order,
  input  logic [XLEN-1:0]        rvfi_pc_rdata,
  input  logic [ILEN-1:0]        rvfi_insn,
  input  logic [4:0]             rvfi_rd_addr,
  input  logic [XLEN-1:0]        rvfi_rd_wdata,
  input  logic                   rvfi_trap,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TRACE_REC_W-1:0] out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [DROP_W-1:0]      dropped,
  output logic                   order_err,
  output logic                   frozen,
  input  logic                   clear
);

  trace_rec_t        rec_in;
  logic              fifo_full, fifo_empty;
  logic              pop, push, drop;

  logic [DROP_W-1:0] dropped_q, dropped_d;
  logic              order_err_q, order_err_d;
  logic              frozen_q, frozen_d;
  logic              seen_q, seen_d;
  logic [63:0]       last_order_q, last_order_d;

  assign rec_in = '{trap:     rvfi_trap,
                    rd_addr:  rvfi_rd_addr,
                    rd_wdata: rvfi_rd_wdata,
                    insn:     rvfi_insn,
                    pc:       rvfi_pc_rdata};

  assign pop  = out_valid & out_ready;
  assign push = rvfi_valid & ~frozen_q & (~fifo_full | pop);
  assign drop = rvfi_valid & ~push;

  sync_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (rec_in),
    .rdata (out_data),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // clear takes priority over drops and order gaps; freeze is applied after clear so a
  // trapping push in the clear cycle still freezes capture.
  always_comb begin
    dropped_d    = dropped_q;
    order_err_d  = order_err_q;
    frozen_d     = frozen_q;
    seen_d       = seen_q;
    last_order_d = last_order_q;

    if (clear) begin
      dropped_d   = '0;
      order_err_d = 1'b0;
      frozen_d    = 1'b0;
      seen_d      = 1'b0;
    end else begin
      if (drop && !(&dropped_q)) dropped_d = dropped_q + 1'b1;
      if (rvfi_valid) begin
        if (seen_q && (rvfi_order != last_order_q + 64'd1)) order_err_d = 1'b1;
        seen_d = 1'b1;
      end
    end

    if (rvfi_valid) last_order_d = rvfi_order;
    if (push && rvfi_trap) frozen_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dropped_q   <= '0;
      order_err_q <= 1'b0;
      frozen_q    <= 1'b0;
      seen_q      <= 1'b0;
    end else begin
      dropped_q   <= dropped_d;
      order_err_q <= order_err_d;
      frozen_q    <= frozen_d;
      seen_q      <= seen_d;
    end
  end

  always_ff @(posedge clk) begin
    last_order_q <= last_order_d;
  end

  assign out_valid = ~fifo_empty;
  assign dropped   = dropped_q;
  assign order_err = order_err_q;
  assign frozen    = frozen_q;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Bench for rvfi_trace_buffer: directed scenarios then random traffic, compared against a
// queue-based reference model; a second instance with a 2-bit drop counter runs in parallel.
module tb_rvfi_trace_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rvfi_valid = 1'b0;
  logic [63:0]  rvfi_order = '0;
  logic [31:0]  rvfi_pc_rdata = '0;
  logic [31:0]  rvfi_insn = '0;
  logic [4:0]   rvfi_rd_addr = '0;
  logic [31:0]  rvfi_rd_wdata = '0;
  logic         rvfi_trap = 1'b0;
  logic         out_ready = 1'b0;
  logic         clear = 1'b0;

  logic         out_valid, out_valid2;
  logic [101:0] out_data, out_data2;
  logic [4:0]   count, count2;
  logic [15:0]  dropped;
  logic [1:0]   dropped2;
  logic         order_err, order_err2;
  logic         frozen, frozen2;

  int errors = 0;
  int checks = 0;

  logic [101:0]    mq[$];
  int              m_drop, m_drop2;
  bit              m_err, m_frozen, m_seen;
  logic [63:0]     m_last;

  always #5 clk = ~clk;

  rvfi_trace_buffer #(.DEPTH(16), .DROP_W(16)) u_dut (
    .clk(clk), .rst(rst), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_trap(rvfi_trap), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count), .dropped(dropped),
    .order_err(order_err), .frozen(frozen), .clear(clear)
  );

  rvfi_trace_buffer #(.DEPTH(16), .DROP_W(2)) u_sat (
    .clk(clk), .rst(rst), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_trap(rvfi_trap), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .count(count2), .dropped(dropped2),
    .order_err(order_err2), .frozen(frozen2), .clear(clear)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("count", 128'(count), 128'(mq.size()));
    check("out_valid", 128'(out_valid), 128'(mq.size() != 0));
    if (mq.size() != 0) check("out_data", 128'(out_data), 128'(mq[0]));
    check("dropped", 128'(dropped), 128'(m_drop));
    check("dropped_sat", 128'(dropped2), 128'(m_drop2));
    check("order_err", 128'(order_err), 128'(m_err));
    check("frozen", 128'(frozen), 128'(m_frozen));
  endtask

  // One clock cycle: drive inputs, advance the reference model, compare after the edge.
  task automatic cyc(input bit r, input bit v, input logic [63:0] ord, input logic [31:0] pc,
                     input bit trap, input bit rdy, input bit clr);
    logic [101:0] rec;
    bit           pop, push;
    rst           = r;
    rvfi_valid    = v;
    rvfi_order    = ord;
    rvfi_pc_rdata = pc;
    rvfi_insn     = $urandom;
    rvfi_rd_addr  = 5'($urandom_range(0, 31));
    rvfi_rd_wdata = $urandom;
    rvfi_trap     = trap;
    out_ready     = rdy;
    clear         = clr;
    rec  = {trap, rvfi_rd_addr, rvfi_rd_wdata, rvfi_insn, pc};
    pop  = (mq.size() != 0) && rdy;
    push = v && !m_frozen && ((mq.size() < 16) || pop);
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      m_drop = 0; m_drop2 = 0; m_err = 0; m_frozen = 0; m_seen = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(rec);
      if (clr) begin
        m_drop = 0; m_drop2 = 0; m_err = 0; m_frozen = 0; m_seen = 0;
      end else begin
        if (v && !push) begin
          if (m_drop < 65535) m_drop++;
          if (m_drop2 < 3) m_drop2++;
        end
        if (v) begin
          if (m_seen && ord != m_last + 64'd1) m_err = 1;
          m_seen = 1;
        end
      end
      if (v) m_last = ord;
      if (push && trap) m_frozen = 1;
    end
    compare_all();
  endtask

  initial begin
    logic [63:0] ord;
    m_drop = 0; m_drop2 = 0; m_err = 0; m_frozen = 0; m_seen = 0; m_last = '0;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst_count", 128'(count), 0);
    check("rst_valid", 128'(out_valid), 0);

    // Three retirements streamed straight through
    cyc(0, 1, 0, 32'h0, 0, 1, 0);
    check("t1_pc0", 128'(out_data[31:0]), 128'h0);
    cyc(0, 1, 1, 32'h4, 0, 1, 0);
    check("t1_pc1", 128'(out_data[31:0]), 128'h4);
    check("t1_cnt", 128'(count), 1);
    cyc(0, 1, 2, 32'h8, 0, 1, 0);
    check("t1_pc2", 128'(out_data[31:0]), 128'h8);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("t1_empty", 128'(out_valid), 0);

    // Fill with sink stalled: 18 retirements into 16 entries
    ord = 3;
    for (int i = 0; i < 18; i++) begin
      cyc(0, 1, ord, 32'h100 + 32'(4 * i), 0, 0, 0);
      ord++;
    end
    check("t2_count", 128'(count), 16);
    check("t2_drop", 128'(dropped), 2);
    check("t2_head", 128'(out_data[31:0]), 128'h100);

    // Full, pop and push in the same cycle
    cyc(0, 1, ord, 32'h200, 0, 1, 0);
    ord++;
    check("t3_count", 128'(count), 16);
    check("t3_drop", 128'(dropped), 2);
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    check("t3_drained", 128'(count), 0);

    // Trap freezes capture
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, ord, 32'h20, 1, 0, 0);
    ord++;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, ord, 32'h24 + 32'(4 * i), 0, 0, 0);
      ord++;
    end
    check("t4_trap", 128'(out_data[101]), 1);
    check("t4_pc", 128'(out_data[31:0]), 128'h20);
    check("t4_frozen", 128'(frozen), 1);
    check("t4_drop", 128'(dropped), 4);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("t4_clr_frz", 128'(frozen), 0);
    check("t4_clr_drop", 128'(dropped), 0);
    cyc(0, 1, ord, 32'h40, 0, 0, 0);
    ord++;
    check("t4_capt", 128'(count), 2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);

    // Order gap detection and re-arm after clear
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 1, 5, 32'h50, 0, 1, 0);
    cyc(0, 1, 6, 32'h54, 0, 1, 0);
    check("t5_noerr", 128'(order_err), 0);
    cyc(0, 1, 8, 32'h58, 0, 1, 0);
    check("t5_err", 128'(order_err), 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("t5_sticky", 128'(order_err), 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 1, 20, 32'h60, 0, 1, 0);
    cyc(0, 1, 21, 32'h64, 0, 1, 0);
    check("t5_rearm", 128'(order_err), 0);
    cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h68, 0, 1, 0);
    cyc(0, 1, 64'h0, 32'h6c, 0, 1, 0);
    check("t5_wrap", 128'(order_err), 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // Saturation of the 2-bit counter: 16 stored, 5 dropped
    ord = 100;
    for (int i = 0; i < 21; i++) begin
      cyc(0, 1, ord, 32'h1000 + 32'(4 * i), 0, 0, 0);
      ord++;
    end
    check("t6_drop", 128'(dropped), 5);
    check("t6_sat", 128'(dropped2), 3);

    // Mid-stream reset discards entries
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("t7_rst", 128'(count), 0);

    // Random traffic
    ord = 64'hFFFF_FFFF_FFFF_FFF0;
    for (int i = 0; i < 600; i++) begin
      bit r, v, t, rd, cl;
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 3) != 0);
      t  = ($urandom_range(0, 31) == 0);
      rd = ($urandom_range(0, 2) == 0);
      cl = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) ord = {$urandom, $urandom};
      cyc(r, v, ord, $urandom, t, rd, cl);
      if (v) ord++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
